// File: rtl/noc_flit_packetizer.sv
// Local-side NoC transmit stage: turns a packet request plus payload stream into
// head/body/tail flits and writes them into the async FIFO write port.
module noc_flit_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int SRC_X      = 0,
  parameter int SRC_Y      = 0
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [1:0]            pkt_dst_x,
  input  logic                  pkt_dst_y,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  input  logic [DATA_WIDTH-3:0] pl_data,
  input  logic                  fifo_full,
  input  logic                  fifo_almost_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  busy,
  output logic [15:0]           pkt_sent_cnt
);

  // state | meaning
  // IDLE  | waiting for a packet request (pkt_ready high)
  // HEAD  | head flit pending; waits while the FIFO is full or almost full
  // BODY  | forwarding payload words; last one goes out as the tail
  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  localparam int          PAD_W    = DATA_WIDTH - 16 - LEN_WIDTH;
  localparam logic [1:0]  SRC_X_L  = 2'(SRC_X);
  localparam logic        SRC_Y_L  = 1'(SRC_Y);

  state_t               state;
  logic [1:0]           dst_x;
  logic                 dst_y;
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH-1:0] cnt;
  logic [7:0]           seq;
  logic [DATA_WIDTH-1:0] head_flit;
  logic                 last_word;

  assign last_word = (cnt == LEN_WIDTH'(1));
  assign head_flit = {(len == '0) ? 2'b11 : 2'b01, dst_x, dst_y, SRC_X_L, SRC_Y_L,
                      len, seq, {PAD_W{1'b0}}};
  assign pkt_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    fifo_wr_en   = 1'b0;
    pl_ready     = 1'b0;
    fifo_wr_data = '0;
    case (state)
      HEAD: begin
        // almost_full only gates the start of a packet; a started one drains
        fifo_wr_en   = !fifo_full && !fifo_almost_full;
        fifo_wr_data = head_flit;
      end
      BODY: begin
        pl_ready     = !fifo_full;
        fifo_wr_en   = pl_valid && !fifo_full;
        fifo_wr_data = {last_word ? 2'b10 : 2'b00, pl_data};
      end
      default: ;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      state        <= IDLE;
      dst_x        <= '0;
      dst_y        <= 1'b0;
      len          <= '0;
      cnt          <= '0;
      seq          <= '0;
      pkt_sent_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pkt_valid) begin
            dst_x <= pkt_dst_x;
            dst_y <= pkt_dst_y;
            len   <= pkt_len;
            cnt   <= pkt_len;
            state <= HEAD;
          end
        end
        HEAD: begin
          if (fifo_wr_en) begin
            if (len == '0) begin
              seq          <= seq + 8'd1;
              pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
              state        <= IDLE;
            end else begin
              state <= BODY;
            end
          end
        end
        BODY: begin
          if (fifo_wr_en) begin
            cnt <= cnt - LEN_WIDTH'(1);
            if (last_word) begin
              seq          <= seq + 8'd1;
              pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
